// File: rtl/if_id_fifo.sv
// if_id_fifo: fetch-to-decode decoupling queue between IF/InstMem and ID.
// Holds {pc, instruction} pairs in a circular buffer and presents the oldest
// entry to ID over a valid/ready handshake. It stalls IF when the buffer is
// full and clears all entries on a jump/branch flush.
// Optional: define IF_ID_PERF_CNT_EN to add the stallCnt output, a saturating
// count of fetch attempts made while the buffer is full.
module if_id_fifo #(
   parameter int PC_LENGTH   = 32,
   parameter int INST_LENGTH = 32,
   parameter int DEPTH       = 4,
   parameter int PTR_W       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   romCe,
   input  logic [PC_LENGTH-1:0]   fetchPc,
   input  logic [INST_LENGTH-1:0] fetchInst,
   input  logic                   flush,
   input  logic                   idReady,
   output logic                   ifStall,
   output logic                   idValid,
   output logic [PC_LENGTH-1:0]   idPc,
   output logic [INST_LENGTH-1:0] idInst,
   output logic [PTR_W:0]         count
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]            stallCnt
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [PC_LENGTH-1:0]   mem_pc_q   [DEPTH];
   logic [INST_LENGTH-1:0] mem_inst_q [DEPTH];

   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic full;
   logic push;
   logic pop;

   // Handshake qualifiers. ifStall depends on occupancy only, so idReady has
   // no combinational path to IF.
   always_comb begin
      full    = (count_q == FULL_CNT);
      idValid = (count_q != '0);
      ifStall = full;
      push    = romCe & ~full & ~flush;
      pop     = idValid & idReady & ~flush;
   end

   // Next-state for pointers and occupancy; flush overrides any push/pop
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are deliberately left untouched by reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc_q[wrPtr_q]   <= fetchPc;
         mem_inst_q[wrPtr_q] <= fetchInst;
      end
   end

   // Head entry to ID; an empty queue presents an all-zero NOP bubble
   always_comb begin
      count  = count_q;
      idPc   = '0;
      idInst = '0;
      if (idValid) begin
         idPc   = mem_pc_q[rdPtr_q];
         idInst = mem_inst_q[rdPtr_q];
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stallCnt_q, stallCnt_d;

   // Saturating count of fetches presented while full; flush does not clear it
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (romCe && full && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 32'd1;
   end

   // Performance counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stallCnt_q <= '0;
      else     stallCnt_q <= stallCnt_d;
   end

   assign stallCnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Testbench for if_id_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the buffer contents.
module tb_if_id_fifo;

   localparam int PCW   = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             romCe;
   logic [PCW-1:0]   fetchPc;
   logic [IW-1:0]    fetchInst;
   logic             flush;
   logic             idReady;
   logic             ifStall;
   logic             idValid;
   logic [PCW-1:0]   idPc;
   logic [IW-1:0]    idInst;
   logic [PTR_W:0]   count;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0]      stallCnt;
`endif

   if_id_fifo #(
      .PC_LENGTH  (PCW),
      .INST_LENGTH(IW),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .romCe    (romCe),
      .fetchPc  (fetchPc),
      .fetchInst(fetchInst),
      .flush    (flush),
      .idReady  (idReady),
      .ifStall  (ifStall),
      .idValid  (idValid),
      .idPc     (idPc),
      .idInst   (idInst),
      .count    (count)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stallCnt (stallCnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic [IW-1:0]  inst;
   } entry_t;

   entry_t      exp_q[$];
   logic [31:0] stall_exp = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched pairs, updated per clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         stall_exp <= '0;
      end else begin
         automatic bit was_full = (exp_q.size() == DEPTH);
         automatic bit do_push  = romCe && !was_full && !flush;
         automatic bit do_pop   = (exp_q.size() != 0) && idReady && !flush;
         if (romCe && was_full && stall_exp != 32'hFFFF_FFFF) stall_exp <= stall_exp + 32'd1;
         if (flush) exp_q.delete();
         else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({fetchPc, fetchInst});
         end
      end
   end

   // Monitor: compares visible DUT state with the model mid-cycle.
   always @(negedge clk) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("ifStall", 64'(ifStall), 64'(exp_q.size() == DEPTH));
      chk("idValid", 64'(idValid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("idPc", 64'(idPc), 64'(exp_q[0].pc));
         chk("idInst", 64'(idInst), 64'(exp_q[0].inst));
      end else begin
         chk("idPc_nop", 64'(idPc), 64'd0);
         chk("idInst_nop", 64'(idInst), 64'd0);
      end
`ifdef IF_ID_PERF_CNT_EN
      chk("stallCnt", 64'(stallCnt), 64'(stall_exp));
`endif
   end

   // One clock of stimulus; returns 1 time unit after the rising edge.
   task automatic drive(input logic rc, input logic [PCW-1:0] pc, input logic fl, input logic rdy);
      romCe     = rc;
      fetchPc   = pc;
      fetchInst = $urandom;
      flush     = fl;
      idReady   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_idValid", 64'(idValid), 64'd0);
      chk("rst_idInst", 64'(idInst), 64'd0);
      chk("rst_ifStall", 64'(ifStall), 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      romCe = 1'b0; fetchPc = '0; fetchInst = '0; flush = 1'b0; idReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("init_count", 64'(count), 64'd0);

      // Reset mid-queue
      for (int i = 0; i < 3; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      chk("pre_rst_count", 64'(count), 64'd3);
      romCe = 1'b0;
      pulse_reset();

      // Streaming: push and pop every cycle
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b1);
         chk("stream_count", 64'(count), 64'd1);
         chk("stream_pc", 64'(idPc), 64'(i * 4));
         chk("stream_stall", 64'(ifStall), 64'd0);
      end
      drive(1'b0, '0, 1'b0, 1'b1);

      // Fill and stall
      for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      chk("fill_count", 64'(count), 64'd4);
      chk("fill_stall", 64'(ifStall), 64'd1);
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      chk("drop_count", 64'(count), 64'd4);
      chk("drop_head", 64'(idPc), 64'h0);
      for (int k = 0; k < 4; k++) begin
         chk("drain_order", 64'(idPc), 64'(k * 4));
         drive(1'b0, '0, 1'b0, 1'b1);
      end
      chk("drain_empty", 64'(idValid), 64'd0);

      // Flush with a coincident fetch
      drive(1'b1, 32'h20, 1'b0, 1'b0);
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      drive(1'b1, 32'h28, 1'b0, 1'b0);
      chk("preflush_count", 64'(count), 64'd3);
      drive(1'b1, 32'h2C, 1'b1, 1'b0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(idValid), 64'd0);
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      chk("jump_head", 64'(idPc), 64'h100);
      chk("jump_count", 64'(count), 64'd1);
      drive(1'b0, '0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC,
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));

`ifdef IF_ID_PERF_CNT_EN
      romCe = 1'b0;
      pulse_reset();
      chk("perf_reset", 64'(stallCnt), 64'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      chk("perf_fill", 64'(stallCnt), 64'd0);
      for (int i = 0; i < 5; i++) drive(1'b1, 32'h10, 1'b0, 1'b0);
      chk("perf_five", 64'(stallCnt), 64'd5);
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("perf_flush", 64'(stallCnt), 64'd5);
      pulse_reset();
      chk("perf_rst", 64'(stallCnt), 64'd0);
`endif

      drive(1'b0, '0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
